// File: rtl/mult_fu_pipe_if.sv
// Issue and FU->CDB bundle for mult_fu_pipe.
// Builds with MULT_UMULH_EN adds the is_umulh issue bit.
`ifndef NUM_ROB
`define NUM_ROB 32
`endif
`ifndef NUM_PR
`define NUM_PR 64
`endif

// Handshakes: an issue is taken on an edge where start && ready are both high;
// a result is retired on an edge where done && CDB_valid are both high.
interface mult_fu_pipe_if #(
  parameter int NUM_ROB = `NUM_ROB,
  parameter int NUM_PR  = `NUM_PR
);
  localparam int ROB_W = $clog2(NUM_ROB);
  localparam int PR_W  = $clog2(NUM_PR);

  logic             start;
  logic [63:0]      opa;
  logic [63:0]      opb;
  logic [PR_W-1:0]  T_idx_in;
  logic [ROB_W-1:0] ROB_idx_in;
  logic [4:0]       dest_idx_in;
`ifdef MULT_UMULH_EN
  logic             is_umulh;
`endif
  logic             ready;

  logic             CDB_valid;
  logic             done;
  logic [63:0]      result;
  logic [PR_W-1:0]  T_idx;
  logic [ROB_W-1:0] ROB_idx;
  logic [4:0]       dest_idx;

  modport master (
`ifdef MULT_UMULH_EN
    output is_umulh,
`endif
    output start, opa, opb, T_idx_in, ROB_idx_in, dest_idx_in, CDB_valid,
    input  ready, done, result, T_idx, ROB_idx, dest_idx
  );

  modport slave (
`ifdef MULT_UMULH_EN
    input  is_umulh,
`endif
    input  start, opa, opb, T_idx_in, ROB_idx_in, dest_idx_in, CDB_valid,
    output ready, done, result, T_idx, ROB_idx, dest_idx
  );
endinterface

// File: rtl/mult_fu_pipe.sv
// Pipelined 64-bit multiply FU feeding the CDB, with back-pressure and rollback squash.
// Optional MULT_UMULH_EN: carries is_umulh and computes the full 128-bit product.
`ifndef NUM_ROB
`define NUM_ROB 32
`endif
`ifndef NUM_PR
`define NUM_PR 64
`endif

module mult_fu_pipe #(
  parameter int MULT_STAGES = 4,
  parameter int NUM_ROB     = `NUM_ROB,
  parameter int NUM_PR      = `NUM_PR
) (
  input  logic                       clock,
  input  logic                       reset,
  mult_fu_pipe_if.slave              fu,
  input  logic                       rollback_en,
  input  logic [$clog2(NUM_ROB)-1:0] ROB_rollback_idx,
  input  logic [$clog2(NUM_ROB)-1:0] diff_ROB
);
  localparam int ROB_W = $clog2(NUM_ROB);
  localparam int PR_W  = $clog2(NUM_PR);
  localparam int K     = 64 / MULT_STAGES;
  localparam int L     = MULT_STAGES - 1;
`ifdef MULT_UMULH_EN
  localparam int PW    = 128;
`else
  localparam int PW    = 64;
`endif
  localparam logic [ROB_W:0] ROB_N = (ROB_W+1)'(NUM_ROB);

  typedef struct packed {
    logic             vld;
`ifdef MULT_UMULH_EN
    logic             umulh;
`endif
    logic [PR_W-1:0]  t;
    logic [ROB_W-1:0] rob;
    logic [4:0]       dest;
    logic [PW-1:0]    prod;
    logic [PW-1:0]    mcand;
    logic [63:0]      mplr;
  } stage_t;

  // Entry is younger than the rollback point and inside the live ROB window.
  function automatic logic squash_f(input logic [ROB_W-1:0] idx, input logic [ROB_W-1:0] rb,
                                    input logic [ROB_W-1:0] lim, input logic en);
    logic [ROB_W:0] diff;
    if (idx >= rb) diff = {1'b0, idx} - {1'b0, rb};
    else           diff = {1'b0, idx} + ROB_N - {1'b0, rb};
    return en && (diff != '0) && (diff <= {1'b0, lim});
  endfunction

  // mcand is stored pre-shifted for the chunk this step consumes.
  function automatic stage_t step_f(input stage_t x);
    stage_t y;
    y       = x;
    y.prod  = x.prod + x.mcand * PW'(x.mplr[K-1:0]);
    y.mcand = x.mcand << K;
    y.mplr  = x.mplr >> K;
    return y;
  endfunction

  stage_t           s   [MULT_STAGES];
  stage_t           s_n [MULT_STAGES];
  stage_t           in_e;
  logic [L:0]       adv;
  logic [L:0]       sq;
  logic             in_sq;
  logic             rdy;

  always_comb begin : issue_entry
    in_e       = '0;
    in_e.vld   = fu.start;
    in_e.t     = fu.T_idx_in;
    in_e.rob   = fu.ROB_idx_in;
    in_e.dest  = fu.dest_idx_in;
`ifdef MULT_UMULH_EN
    in_e.umulh = fu.is_umulh;
`endif
    in_e.prod  = PW'(fu.opa) * PW'(fu.opb[K-1:0]);
    in_e.mcand = PW'(fu.opa) << K;
    in_e.mplr  = fu.opb >> K;
  end

  // A stage advances when any stage downstream is empty or the output is free.
  always_comb begin : advance
    logic chain;
    sq    = '0;
    adv   = '0;
    for (int i = 0; i < MULT_STAGES; i++)
      sq[i] = squash_f(s[i].rob, ROB_rollback_idx, diff_ROB, rollback_en);
    in_sq = squash_f(fu.ROB_idx_in, ROB_rollback_idx, diff_ROB, rollback_en);
    chain  = !s[L].vld || fu.CDB_valid;
    adv[L] = chain;
    for (int i = L - 1; i >= 0; i--) begin
      chain  = chain || !s[i+1].vld;
      adv[i] = chain;
    end
    rdy = !s[0].vld || adv[0];
  end

  always_comb begin : next_state
    s_n = s;
    if (rdy) s_n[0] = (fu.start && !in_sq) ? in_e : '0;
    else     s_n[0] = sq[0] ? '0 : s[0];
    for (int i = 1; i < MULT_STAGES; i++) begin
      if (adv[i-1]) s_n[i] = (s[i-1].vld && !sq[i-1]) ? step_f(s[i-1]) : '0;
      else          s_n[i] = sq[i] ? '0 : s[i];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) s <= '{default: '0};
    else       s <= s_n;
  end

  assign fu.ready    = rdy;
  assign fu.done     = s[L].vld && !sq[L];
  assign fu.T_idx    = s[L].t;
  assign fu.ROB_idx  = s[L].rob;
  assign fu.dest_idx = s[L].dest;
`ifdef MULT_UMULH_EN
  assign fu.result   = s[L].umulh ? s[L].prod[127:64] : s[L].prod[63:0];
`else
  assign fu.result   = s[L].prod[63:0];
`endif
endmodule

// File: tb/tb_mult_fu_pipe.sv
// Directed and random stimulus for mult_fu_pipe against a queue-based product model.
// Define MULT_UMULH_EN to also exercise the high-half result.
module tb_mult_fu_pipe;
  localparam int S     = 4;
  localparam int NR    = 32;
  localparam int NP    = 64;
  localparam int ROB_W = 5;
  localparam int PR_W  = 6;

  logic             clock = 1'b0;
  logic             reset;
  logic             rollback_en;
  logic [ROB_W-1:0] rb_idx;
  logic [ROB_W-1:0] diff_rob;
  logic             cur_hi;

  mult_fu_pipe_if #(.NUM_ROB(NR), .NUM_PR(NP)) bus ();

  mult_fu_pipe #(.MULT_STAGES(S), .NUM_ROB(NR), .NUM_PR(NP)) dut (
    .clock            (clock),
    .reset            (reset),
    .fu               (bus),
    .rollback_en      (rollback_en),
    .ROB_rollback_idx (rb_idx),
    .diff_ROB         (diff_rob)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [ROB_W-1:0] rob;
    logic [PR_W-1:0]  t;
    logic [4:0]       d;
    logic [63:0]      res;
    int               elig;
  } txn_t;

  txn_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   stall       = 0;
  int   n_done      = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_sq(input logic [ROB_W-1:0] rob);
    int d;
    d = (int'(rob) - int'(rb_idx) + NR) % NR;
    return rollback_en && d != 0 && d <= int'(diff_rob);
  endfunction

  function automatic logic [63:0] model_prod(input logic [63:0] a, input logic [63:0] b, input logic hi);
    logic [127:0] p;
    p = {64'd0, a} * {64'd0, b};
    return hi ? p[127:64] : p[63:0];
  endfunction

  task automatic drive(input logic st, input logic [63:0] a, input logic [63:0] b,
                       input logic [ROB_W-1:0] rob, input logic [PR_W-1:0] t,
                       input logic [4:0] d, input logic hi);
    bus.start       = st;
    bus.opa         = a;
    bus.opb         = b;
    bus.ROB_idx_in  = rob;
    bus.T_idx_in    = t;
    bus.dest_idx_in = d;
`ifdef MULT_UMULH_EN
    bus.is_umulh    = hi;
    cur_hi          = hi;
`else
    cur_hi          = 1'b0;
    if (hi) cur_hi  = 1'b0;
`endif
  endtask

  // One clock cycle: check outputs against the model, then update the model at the edge.
  task automatic tick();
    logic done_s, cdb_s, rdy_exp, sq_f;
    txn_t keep[$];
    #1;
    rdy_exp = (exp_q.size() < S) || bus.CDB_valid;
    done_s  = bus.done;
    cdb_s   = bus.CDB_valid;
    if (!reset) begin
      check("ready", bus.ready, rdy_exp);
      if (exp_q.size() == 0) check("idle_done", bus.done, 0);
      else begin
        sq_f = is_sq(exp_q[0].rob);
        if (done_s) begin
          check("result", bus.result, exp_q[0].res);
          check("rob_idx", bus.ROB_idx, exp_q[0].rob);
          check("t_idx", bus.T_idx, exp_q[0].t);
          check("dest_idx", bus.dest_idx, exp_q[0].d);
          check("early_done", cyc >= exp_q[0].elig, 1);
          check("squashed_shown", sq_f, 0);
          stall = 0;
        end else if (cdb_s && !sq_f && cyc >= exp_q[0].elig) begin
          stall++;
          check("stall", stall > S + 2, 0);
        end else stall = 0;
      end
    end
    @(posedge clock);
    if (reset) begin
      exp_q.delete();
      stall = 0;
    end else begin
      if (done_s && cdb_s && exp_q.size() != 0) begin
        n_done++;
        void'(exp_q.pop_front());
      end
      foreach (exp_q[j]) if (!is_sq(exp_q[j].rob)) keep.push_back(exp_q[j]);
      exp_q = keep;
      if (bus.start && rdy_exp && !is_sq(bus.ROB_idx_in))
        exp_q.push_back('{rob: bus.ROB_idx_in, t: bus.T_idx_in, d: bus.dest_idx_in,
                          res: model_prod(bus.opa, bus.opb, cur_hi), elig: cyc + S});
    end
    cyc++;
    @(negedge clock);
  endtask

  task automatic drain();
    int k;
    k = 0;
    bus.start = 1'b0;
    bus.CDB_valid = 1'b1;
    while (exp_q.size() != 0 && k < 100) begin
      tick();
      k++;
    end
    check("drain_empty", exp_q.size(), 0);
    repeat (2) tick();
  endtask

  initial begin
    int n0, k;
    logic [ROB_W-1:0] rc;
    reset = 1'b1;
    rollback_en = 1'b0;
    rb_idx = '0;
    diff_rob = '0;
    bus.CDB_valid = 1'b1;
    drive(0, 64'd0, 64'd0, '0, '0, '0, 0);
    @(negedge clock);
    repeat (2) tick();
    reset = 1'b0;
    #1;
    check("rst_done", bus.done, 0);
    check("rst_ready", bus.ready, 1);
    check("rst_result", bus.result, 0);
    check("rst_t_idx", bus.T_idx, 0);
    check("rst_rob_idx", bus.ROB_idx, 0);
    check("rst_dest_idx", bus.dest_idx, 0);

    // Basic latency
    drive(1, 64'd7, 64'd6, 5'd3, 6'd9, 5'd5, 0);
    tick();
    bus.start = 1'b0;
    repeat (S - 1) begin
      #1;
      check("basic_early", bus.done, 0);
      tick();
    end
    #1;
    check("basic_done", bus.done, 1);
    check("basic_result", bus.result, 64'd42);
    check("basic_rob", bus.ROB_idx, 5'd3);
    check("basic_t", bus.T_idx, 6'd9);
    check("basic_dest", bus.dest_idx, 5'd5);
    tick();
    drain();

    // Streaming
    rc = 5'd8;
    for (int i = 0; i < 8; i++) begin
      drive(1, 64'(i), 64'(i + 1), rc, PR_W'($urandom), 5'($urandom), 0);
      rc++;
      #1;
      check("stream_ready", bus.ready, 1);
      if (i >= S) check("stream_done", bus.done, 1);
      tick();
    end
    bus.start = 1'b0;
    repeat (S) begin
      #1;
      check("stream_tail_done", bus.done, 1);
      tick();
    end
    drain();

    // Back-pressure
    n0 = n_done;
    bus.CDB_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1, {$urandom, $urandom}, {$urandom, $urandom}, rc, PR_W'($urandom), 5'($urandom), 0);
      #1;
      check("bp_ready", bus.ready, i < 4);
      tick();
      if (i < 4) rc++;
    end
    #1;
    check("bp_full_ready", bus.ready, 0);
    check("bp_held_done", bus.done, 1);
    tick();
    bus.CDB_valid = 1'b1;
    #1;
    check("bp_release_ready", bus.ready, 1);
    tick();
    rc++;
    drain();
    check("bp_count", n_done - n0, 5);

    // Rollback across ROB wrap
    n0 = n_done;
    drive(1, 64'd3, 64'd5, 5'd30, 6'd1, 5'd1, 0); tick();
    drive(1, 64'd4, 64'd5, 5'd31, 6'd2, 5'd2, 0); tick();
    drive(1, 64'd5, 64'd5, 5'd0,  6'd3, 5'd3, 0); tick();
    drive(1, 64'd6, 64'd5, 5'd1,  6'd4, 5'd4, 0); tick();
    bus.start = 1'b0;
    rollback_en = 1'b1; rb_idx = 5'd31; diff_rob = 5'd3;
    tick();
    rollback_en = 1'b0;
    drain();
    check("wrap_count", n_done - n0, 2);

    // Rollback of the held output entry
    bus.CDB_valid = 1'b0;
    drive(1, 64'd11, 64'd13, 5'd5, 6'd10, 5'd7, 0); tick();
    drive(1, 64'd17, 64'd19, 5'd6, 6'd11, 5'd8, 0); tick();
    bus.start = 1'b0;
    repeat (S - 2) tick();
    #1;
    check("rbo_held_done", bus.done, 1);
    check("rbo_held_rob", bus.ROB_idx, 5'd5);
    rollback_en = 1'b1; rb_idx = 5'd4; diff_rob = 5'd1;
    #1;
    check("rbo_done_drop", bus.done, 0);
    tick();
    rollback_en = 1'b0;
    bus.CDB_valid = 1'b1;
    k = 0;
    #1;
    while (!bus.done && k < 8) begin
      tick();
      #1;
      k++;
    end
    check("rbo_next_done", bus.done, 1);
    check("rbo_next_rob", bus.ROB_idx, 5'd6);
    check("rbo_next_result", bus.result, 64'd323);
    drain();

    // Wide product
    drive(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd12, 6'd5, 5'd9, 0);
    tick();
`ifdef MULT_UMULH_EN
    drive(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd13, 6'd6, 5'd10, 1);
`else
    bus.start = 1'b0;
`endif
    tick();
    bus.start = 1'b0;
    repeat (S - 2) tick();
    #1;
    check("wide_lo", bus.result, 64'h1);
    tick();
`ifdef MULT_UMULH_EN
    #1;
    check("wide_hi", bus.result, 64'hFFFF_FFFF_FFFF_FFFE);
`endif
    drain();

    // Reset mid-operation
    drive(1, 64'd9, 64'd9, 5'd20, 6'd1, 5'd1, 0); tick();
    drive(1, 64'd8, 64'd8, 5'd21, 6'd2, 5'd2, 0); tick();
    bus.start = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("midrst_done", bus.done, 0);
    check("midrst_ready", bus.ready, 1);
    check("midrst_result", bus.result, 0);
    drain();

    // Random traffic with back-pressure and rollbacks
    repeat (400) begin
      drive($urandom_range(0, 3) != 0, {$urandom, $urandom}, {$urandom, $urandom},
            ROB_W'($urandom), PR_W'($urandom), 5'($urandom), 1'($urandom));
      bus.CDB_valid = $urandom_range(0, 3) != 0;
      rollback_en   = $urandom_range(0, 19) == 0;
      rb_idx        = ROB_W'($urandom);
      diff_rob      = ROB_W'($urandom);
      tick();
    end
    rollback_en = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
